ir_queue: RTL and testbench
===========================

# ir_queue

Parametrised instruction register with a prefetch queue for the multicycle CPU, sitting between instruction memory and the control/decode stage. Fetched words are buffered in a DEPTH-entry FIFO with valid/ready handshakes. The popped word is captured into a clocked, reset-able instruction register that holds stable for the remaining cycles of the instruction and exposes the decoded MIPS fields. A flush input discards queued prefetches on branches and jumps.

## Interface
- WIDTH, 32: instruction width; decoded fields assume 32.
- DEPTH, 4: queue entries; power of two, ≥2.
- PC_W, 32: width of the PC tag carried with each word.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued entries.
- in_valid  in  1  fetch word present.
- in_ready  out  1  queue can accept (count < DEPTH).
- in_instr  in  WIDTH  fetched instruction.
- in_pc  in  PC_W  address of in_instr.
- out_valid  out  1  queue head valid (count != 0).
- out_ready  in  1  control consumes head (IR load strobe).
- count  out  $clog2(DEPTH)+1  occupancy.
- ir  out  WIDTH  instruction register.
- ir_pc  out  PC_W  PC of ir.
- opcode, rs, rt, rd, shamt, funct  out  6,5,5,5,5,6  fields of ir ([31:26],[25:21],[20:16],[15:11],[10:6],[5:0]).
- imm16  out  16  ir[15:0].
- addr26  out  26  ir[25:0].

## Operation
- push = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
- Push writes {in_instr, in_pc} at wr_ptr, wr_ptr++; pop advances rd_ptr. Pointers are $clog2(DEPTH) bits and wrap naturally.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Head is show-ahead: the queue presents the head entry combinationally from storage (not an output port). It is consumed only via pop.
- On pop: ir <= head instr, ir_pc <= head pc. Otherwise ir and ir_pc hold. This replaces the old level-sensitive latch with a true register.
- Decoded fields are pure slices of ir. No decode logic.
- flush: rd_ptr = wr_ptr = 0, count = 0 on that edge. Any same-cycle push/pop is ignored. ir and ir_pc are not modified.
- in_ready depends only on count, never on out_ready. Full with simultaneous pop still refuses push.
- in_valid while !in_ready: the word is not accepted. The upstream must hold it.

## Timing
- Reset values: count=0, in_ready=1, out_valid=0, ir=0, ir_pc=0, all fields 0. Pointers are 0. Storage contents are not reset.
- Push at edge k → out_valid=1 after edge k (latency 1). Empty-queue bypass is not allowed.
- Pop at edge k → ir updated after edge k. Decoded fields are valid in the same cycle.
- Full (count=DEPTH): in_ready=0. Empty: out_valid=0, out_ready is ignored, and ir holds.
- rst has priority over flush, and flush over push/pop. rst mid-stream drops everything, including ir.

## Structure
- Package ir_pkg: field bit-position constants (OP_HI/LO, RS_*, RT_*, RD_*, SHAMT_*, FUNCT_*, IMM_*, ADDR_*) and opcode localparams used by control.
- One sub-module, ir_fifo (parametrised storage + pointers + count). The top adds the IR register and field slicing.

## Test plan
- Reset: hold rst 2 cycles → count=0, in_ready=1, out_valid=0, ir=0.
- Fill/drain: push 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 (pc 0,4,8,C), DEPTH=4 → in_ready=0 at count=4. A 5th word is refused. Pop ×4 → ir follows in order, with opcode=0x08,0x08,0x00,0x2B and rd=10 for the third word.
- Simultaneous push+pop at count=2 → count stays 2, and FIFO order is preserved across pointer wrap (≥3 wraps).
- Hold: out_ready=0 for 5 cycles after ir=0x01095020 → ir, funct=0x20, and ir_pc=8 stay constant.
- Flush with in_valid=1 and out_ready=1 at count=3 → count=0, the word is not enqueued, and ir is unchanged. The next push appears after 1 cycle.
- rst asserted at count=2 mid-pop → ir=0, count=0 the next cycle.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared constants for the instruction register / prefetch queue.
// Field bit positions and the opcode values that control decodes.
package ir_pkg;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int ADDR_HI  = 25;
  localparam int ADDR_LO  = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/ir_fifo.sv
// Prefetch FIFO: word+PC storage, wrapping pointers and occupancy.
// Head is presented show-ahead straight from storage.
module ir_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_instr,
  output logic [PC_W-1:0]          head_pc,
  output logic                     pop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_instr [DEPTH];
  logic [PC_W-1:0]  mem_pc    [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;

  assign in_ready   = count < CW'(DEPTH);
  assign out_valid  = count != '0;
  assign push       = in_valid && in_ready && !flush;
  assign pop        = out_valid && out_ready && !flush;
  assign head_instr = mem_instr[rd_ptr];
  assign head_pc    = mem_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

endmodule

// File: rtl/ir_queue.sv
// Instruction register fed by a prefetch queue; exposes MIPS fields.
// ir loads only on a pop and otherwise holds for the instruction.
module ir_queue
  import ir_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       ir,
  output logic [PC_W-1:0]        ir_pc,
  output logic [5:0]             opcode,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [4:0]             shamt,
  output logic [5:0]             funct,
  output logic [15:0]            imm16,
  output logic [25:0]            addr26
);

  logic [WIDTH-1:0] head_instr;
  logic [PC_W-1:0]  head_pc;
  logic             pop;

  ir_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .pop        (pop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ir    <= '0;
      ir_pc <= '0;
    end else if (pop) begin
      ir    <= head_instr;
      ir_pc <= head_pc;
    end
  end

  assign opcode = ir[OP_HI:OP_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign shamt  = ir[SHAMT_HI:SHAMT_LO];
  assign funct  = ir[FUNCT_HI:FUNCT_LO];
  assign imm16  = ir[IMM_HI:IMM_LO];
  assign addr26 = ir[ADDR_HI:ADDR_LO];

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue with a queue-based scoreboard.
// Expected IR values come from the bench's own occupancy model.
module tb_ir_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  count;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] addr26;

  int errors = 0;
  int checks = 0;
  int mcount = 0;
  bit known = 0;
  logic [31:0] eir = '0;
  logic [31:0] epc = '0;
  logic [63:0] sb [$];
  logic [31:0] saved;

  ir_queue #(.WIDTH(32), .DEPTH(4), .PC_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .imm16     (imm16),
    .addr26    (addr26)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic v,
                     input logic rdy, input logic [31:0] ins,
                     input logic [31:0] pc);
    logic pu;
    logic po;
    logic [63:0] e;
    rst = r;
    flush = f;
    in_valid = v;
    out_ready = rdy;
    in_instr = ins;
    in_pc = pc;
    pu = v && (mcount < 4) && !f;
    po = (mcount != 0) && rdy && !f;
    #1;
    if (known) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, mcount < 4});
      chk("out_valid", {31'b0, out_valid}, {31'b0, mcount != 0});
    end
    @(posedge clk);
    #1;
    if (r) begin
      mcount = 0;
      sb.delete();
      eir = '0;
      epc = '0;
      known = 1;
    end else if (f) begin
      mcount = 0;
      sb.delete();
    end else begin
      if (po) begin
        e = sb.pop_front();
        eir = e[31:0];
        epc = e[63:32];
      end
      if (pu) sb.push_back({pc, ins});
      mcount = mcount + int'(pu) - int'(po);
    end
    if (known) begin
      chk("count", {29'b0, count}, mcount[31:0]);
      chk("ir", ir, eir);
      chk("ir_pc", ir_pc, epc);
    end
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_opcode", {26'b0, opcode}, 32'd0);

    cyc(0, 0, 1, 0, 32'h20080005, 32'h0);
    chk("lat1_out_valid", {31'b0, out_valid}, 32'd1);
    cyc(0, 0, 1, 0, 32'h20090003, 32'h4);
    cyc(0, 0, 1, 0, 32'h01095020, 32'h8);
    cyc(0, 0, 1, 0, 32'hAC0A0000, 32'hC);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    cyc(0, 0, 1, 0, 32'hDEADBEEF, 32'h10);
    cyc(0, 0, 1, 1, 32'hDEADBEEF, 32'h10);
    chk("op0", {26'b0, opcode}, 32'h08);
    chk("full_pop_count", {29'b0, count}, 32'd3);
    in_valid = 1'b0;
    cyc(0, 0, 0, 1, 0, 0);
    chk("op1", {26'b0, opcode}, 32'h08);
    cyc(0, 0, 0, 1, 0, 0);
    chk("op2", {26'b0, opcode}, 32'h00);
    chk("rd2", {27'b0, rd}, 32'd10);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("hold_ir", ir, 32'h01095020);
      chk("hold_funct", {26'b0, funct}, 32'h20);
      chk("hold_pc", ir_pc, 32'h8);
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("op3", {26'b0, opcode}, 32'h2B);
    cyc(0, 0, 0, 1, 0, 0);
    chk("empty_ir_hold", ir, 32'hAC0A0000);

    cyc(0, 0, 1, 0, 32'h10000000, 32'h100);
    cyc(0, 0, 1, 0, 32'h10000001, 32'h104);
    for (int i = 2; i < 16; i++) begin
      cyc(0, 0, 1, 1, 32'h10000000 + i, 32'h100 + 4 * i);
      chk("wrap_count", {29'b0, count}, 32'd2);
      chk("wrap_ir", ir, 32'h10000000 + i - 2);
    end
    cyc(0, 0, 1, 0, 32'h2000000A, 32'h200);

    saved = eir;
    cyc(0, 1, 1, 1, 32'h3000000B, 32'h204);
    chk("flush_count", {29'b0, count}, 32'd0);
    chk("flush_ir", ir, saved);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    cyc(0, 0, 1, 0, 32'h2010FFFF, 32'h300);
    chk("post_flush_valid", {31'b0, out_valid}, 32'd1);
    cyc(0, 0, 1, 1, 32'h2011ABCD, 32'h304);
    chk("post_flush_ir", ir, 32'h2010FFFF);
    chk("post_flush_imm", {16'b0, imm16}, 32'hFFFF);
    chk("post_flush_rt", {27'b0, rt}, 32'd16);
    cyc(0, 0, 1, 0, 32'h08000040, 32'h308);
    cyc(1, 0, 1, 1, 32'h0, 32'h30C);
    chk("rst_mid_ir", ir, 32'h0);
    chk("rst_mid_count", {29'b0, count}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
